// File: rtl/i2s_clk_gen.sv
// I2S BCLK/LRCK/reset generator with frame-aligned divider reload.
// Optional MCLK output when I2S_MCLK_OUT_EN is defined.
module i2s_clk_gen #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_DIV  = 34,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned RST_HOLD = 4
`ifdef I2S_MCLK_OUT_EN
  ,
  parameter int unsigned MCLK_DIV = 0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_ld,
  input  logic [DIV_W-1:0] div_val,
  output logic             bclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             lrck,
  output logic             frame_start,
  output logic             i2s_rst_n,
  output logic [DIV_W-1:0] div_cur
`ifdef I2S_MCLK_OUT_EN
  ,
  output logic             mclk
`endif
);

  localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_W - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             bclk_q, bclk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             lrck_q, lrck_d;
  logic             fs_q, fs_d;
  logic             rstn_q, rstn_d;

  logic run, tick, bfall;
  logic slot_end, frame_end, go_idle;

`ifdef I2S_MCLK_OUT_EN
  localparam int MW = (MCLK_DIV > 0) ? $clog2(MCLK_DIV + 1) : 1;
  localparam logic [MW-1:0] MC_LAST = MW'(MCLK_DIV);
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          mclk_q, mclk_d;
`endif

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    bclk_d     = bclk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    lrck_d     = lrck_q;
    fs_d       = 1'b0;
    rstn_d     = rstn_q;
    go_idle    = 1'b0;

    run       = (state_q != S_IDLE);
    tick      = (div_cnt_q == div_cur_q);
    bfall     = run && tick && bclk_q;
    slot_end  = bfall && (bit_cnt_q == SLOT_LAST);
    frame_end = slot_end && lrck_q;

    if (run) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) bclk_d = ~bclk_q;
      rise_d = tick && !bclk_q;
      fall_d = bfall;
      if (bfall) bit_cnt_d = slot_end ? '0 : bit_cnt_q + 1'b1;
      if (slot_end) lrck_d = ~lrck_q;
      fs_d = frame_end;
    end

    // Old pending value lands first; a load in this cycle waits a frame.
    if (frame_end && pend_vld_q) begin
      div_cur_d  = pend_q;
      pend_vld_d = 1'b0;
    end
    if (div_ld) begin
      if (run) begin
        pend_d     = div_val;
        pend_vld_d = 1'b1;
      end else begin
        div_cur_d = div_val;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_HOLD;
          fs_d    = 1'b1;
        end
      end
      S_HOLD: begin
        if (!en) begin
          go_idle = 1'b1;
        end else if (bfall) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = S_RUN;
            rstn_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!en) state_d = S_STOP;
      end
      S_STOP: begin
        if (en) state_d = S_RUN;
        else if (frame_end) go_idle = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Entering IDLE settles any pending divider; an IDLE-style load wins.
    if (go_idle) begin
      state_d    = S_IDLE;
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      hold_cnt_d = '0;
      bclk_d     = 1'b0;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      lrck_d     = 1'b0;
      fs_d       = 1'b0;
      rstn_d     = 1'b0;
      if (pend_vld_q) div_cur_d = pend_q;
      if (div_ld) div_cur_d = div_val;
      pend_vld_d = 1'b0;
    end

`ifdef I2S_MCLK_OUT_EN
    mcnt_d = mcnt_q;
    mclk_d = mclk_q;
    if (run) begin
      if (mcnt_q == MC_LAST) begin
        mcnt_d = '0;
        mclk_d = ~mclk_q;
      end else begin
        mcnt_d = mcnt_q + 1'b1;
      end
    end
    if (go_idle) begin
      mcnt_d = '0;
      mclk_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      div_cur_q  <= DIV_W'(DEF_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      bclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      lrck_q     <= 1'b0;
      fs_q       <= 1'b0;
      rstn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      bclk_q     <= bclk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      lrck_q     <= lrck_d;
      fs_q       <= fs_d;
      rstn_q     <= rstn_d;
    end
  end

`ifdef I2S_MCLK_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mcnt_q <= '0;
      mclk_q <= 1'b0;
    end else begin
      mcnt_q <= mcnt_d;
      mclk_q <= mclk_d;
    end
  end

  assign mclk = mclk_q;
`endif

  assign bclk        = bclk_q;
  assign bclk_rise   = rise_q;
  assign bclk_fall   = fall_q;
  assign lrck        = lrck_q;
  assign frame_start = fs_q;
  assign i2s_rst_n   = rstn_q;
  assign div_cur     = div_cur_q;

endmodule
